// File: rtl/bp_read_control_if.sv
`default_nettype none
// ============================================================================
//  Module      : bp_read_control_if
//  Description : Bundle of the request, DDR read-return and BP write signals
//                of the DDR-to-BP load path.
//  Revision    : 1.0 - initial release
// ============================================================================
interface bp_read_control_if #(
  parameter int X_MAC        = 4,
  parameter int X_MESH       = 16,
  parameter int DDR_ADDR_LEN = 32,
  parameter int ADDR_LEN     = 16,
  parameter int DATA_LEN     = 16,
  parameter int DDR_DATA_LEN = 256,
  parameter int SINGLE_LEN   = 24,
  parameter int BUFFER_NUM   = X_MAC * X_MESH
);
  // Configuration / request
  logic                           conf;
  logic [SINGLE_LEN-1:0]          data_ddr_byte;
  logic [DDR_ADDR_LEN-1:0]        ddr_st_addr;
  logic [ADDR_LEN-1:0]            BP_st_addr;
  logic [1:0]                     BP_st_num;
  logic [SINGLE_LEN-1:0]          Line_width;
  logic                           axi_dg_idle;
  logic [DDR_ADDR_LEN-1:0]        ddr_st_addr_out;
  logic [SINGLE_LEN-1:0]          ddr_len;
  logic                           ddr_conf;
  // DDR read return
  logic                           ddr_read_valid;
  logic [DDR_DATA_LEN-1:0]        ddr_read_data;
  logic                           ddr_read_ready;
  // BP write side
  logic                           bp_hold;
  logic [ADDR_LEN*BUFFER_NUM-1:0] BP_addr_out;
  logic [DATA_LEN*BUFFER_NUM-1:0] BP_data_out;
  logic [BUFFER_NUM-1:0]          BP_wr_en;
  logic                           idle;

  // Load-path block side
  modport slave (
    input  conf, data_ddr_byte, ddr_st_addr, BP_st_addr, BP_st_num, Line_width,
    input  axi_dg_idle, ddr_read_valid, ddr_read_data, bp_hold,
    output ddr_st_addr_out, ddr_len, ddr_conf, ddr_read_ready,
    output BP_addr_out, BP_data_out, BP_wr_en, idle
  );

  // Controller / AXI engine / BP side
  modport master (
    output conf, data_ddr_byte, ddr_st_addr, BP_st_addr, BP_st_num, Line_width,
    output axi_dg_idle, ddr_read_valid, ddr_read_data, bp_hold,
    input  ddr_st_addr_out, ddr_len, ddr_conf, ddr_read_ready,
    input  BP_addr_out, BP_data_out, BP_wr_en, idle
  );
endinterface
`default_nettype wire

// File: rtl/bp_read_control.sv
`default_nettype none
// ============================================================================
//  Module      : bp_read_control
//  Description : DDR-to-BP load path. Issues one DDR read request per conf,
//                buffers returned beats in a small FIFO and scatters each beat
//                into the BP buffers of one MAC group, two lines per transfer.
//  Revision    : 1.0 - initial release
// ============================================================================
module bp_read_control #(
  parameter int X_MAC        = 4,
  parameter int X_MESH       = 16,
  parameter int DDR_ADDR_LEN = 32,
  parameter int ADDR_LEN     = 16,
  parameter int DATA_LEN     = 16,
  parameter int DDR_DATA_LEN = 256,
  parameter int SINGLE_LEN   = 24,
  parameter int FIFO_DEPTH   = 16,
  parameter int BUFFER_NUM   = X_MAC * X_MESH
) (
  input  logic              clk,
  input  logic              rst,
  bp_read_control_if.slave  bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  // Control state and latched configuration
  logic [1:0]              r_state;
  logic [SINGLE_LEN-1:0]   r_line_width;
  logic [ADDR_LEN-1:0]     r_bp_st_addr;
  logic [1:0]              r_bp_st_num;
  logic                    r_count_line;
  logic [SINGLE_LEN-1:0]   r_count_in_line;

  // DDR request registers
  logic                    r_ddr_conf;
  logic [SINGLE_LEN-1:0]   r_ddr_len;
  logic [DDR_ADDR_LEN-1:0] r_ddr_addr;

  // BP write registers
  logic [BUFFER_NUM-1:0]   r_wr_en;
  logic [ADDR_LEN-1:0]     r_bp_addr;
  logic [DDR_DATA_LEN-1:0] r_beat;

  // Beat FIFO
  logic [DDR_DATA_LEN-1:0] r_fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        r_wr_ptr;
  logic [PTR_W-1:0]        r_rd_ptr;
  logic [PTR_W:0]          r_fifo_count;

  logic                    w_start;
  logic                    w_ready;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_fifo_empty;
  logic                    w_fifo_full;
  logic                    w_last_in_line;
  logic [1:0]              w_group;
  logic [BUFFER_NUM-1:0]   w_group_mask;
  logic [ADDR_LEN*BUFFER_NUM-1:0] w_bp_addr;
  logic [DATA_LEN*BUFFER_NUM-1:0] w_bp_data;

  // A new transfer starts only from IDLE; a start also flushes stale beats,
  // so a beat arriving in the same cycle is dropped with them.
  assign w_start        = (r_state == S_IDLE) && bus.conf;
  // Three entries of slack absorb beats the engine may still push after ready drops.
  assign w_ready        = r_fifo_count <= (PTR_W+1)'(FIFO_DEPTH - 4);
  assign w_push         = bus.ddr_read_valid && w_ready && !w_start;
  assign w_fifo_empty   = (r_fifo_count == '0);
  assign w_fifo_full    = (r_fifo_count == (PTR_W+1)'(FIFO_DEPTH));
  assign w_pop          = (r_state == S_RUN) && !w_fifo_empty && !bus.bp_hold;
  assign w_last_in_line = (r_count_in_line == r_line_width - SINGLE_LEN'(1));
  assign w_group        = r_bp_st_num + {1'b0, r_count_line};

  // Fan the registered beat and address out to every buffer; enable only the active group.
  always_comb begin
    w_group_mask = '0;
    w_bp_addr    = '0;
    w_bp_data    = '0;
    for (int m = 0; m < X_MESH; m++) begin
      for (int n = 0; n < X_MAC; n++) begin
        w_group_mask[n + m*X_MAC] = (w_group == 2'(n));
        w_bp_addr[(n + m*X_MAC)*ADDR_LEN +: ADDR_LEN] = r_bp_addr;
        w_bp_data[(n + m*X_MAC)*DATA_LEN +: DATA_LEN] = r_beat[m*DATA_LEN +: DATA_LEN];
      end
    end
  end

  // FIFO pointers and occupancy; cleared on reset and on every accepted start.
  always_ff @(posedge clk) begin
    if (rst || w_start) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_fifo_count <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_fifo_count <= r_fifo_count + (PTR_W+1)'(1);
        2'b01:   r_fifo_count <= r_fifo_count - (PTR_W+1)'(1);
        default: r_fifo_count <= r_fifo_count;
      endcase
    end
  end

  // FIFO storage; the ready threshold must keep pushes away from a full FIFO.
  always_ff @(posedge clk) begin
    if (w_push) r_fifo_mem[r_wr_ptr] <= bus.ddr_read_data;
    if (!rst && w_push) assert (!w_fifo_full);
  end

  // Transfer sequencing: request issue, per-line beat counting, drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_line_width    <= '0;
      r_bp_st_addr    <= '0;
      r_bp_st_num     <= '0;
      r_count_line    <= 1'b0;
      r_count_in_line <= '0;
      r_ddr_conf      <= 1'b0;
      r_ddr_len       <= '0;
      r_ddr_addr      <= '0;
    end else begin
      r_ddr_conf <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.conf) begin
            r_line_width    <= bus.Line_width;
            r_bp_st_addr    <= bus.BP_st_addr;
            r_bp_st_num     <= bus.BP_st_num;
            r_ddr_addr      <= bus.ddr_st_addr;
            r_ddr_len       <= bus.data_ddr_byte;
            r_ddr_conf      <= 1'b1;
            r_count_line    <= 1'b0;
            r_count_in_line <= '0;
            // A zero-width transfer still requests from DDR but writes nothing.
            r_state         <= (bus.Line_width == '0) ? S_IDLE : S_RUN;
          end
        end
        S_RUN: begin
          if (w_pop) begin
            if (w_last_in_line) begin
              if (!r_count_line) begin
                r_count_in_line <= '0;
                r_count_line    <= 1'b1;
              end else begin
                r_state <= S_DRAIN;
              end
            end else begin
              r_count_in_line <= r_count_in_line + SINGLE_LEN'(1);
            end
          end
        end
        S_DRAIN: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // BP write stage: a popped beat is written one cycle after the pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_en   <= '0;
      r_bp_addr <= '0;
      r_beat    <= '0;
    end else begin
      r_wr_en <= w_pop ? w_group_mask : '0;
      if (w_pop) begin
        r_bp_addr <= r_bp_st_addr + r_count_in_line[ADDR_LEN-1:0];
        r_beat    <= r_fifo_mem[r_rd_ptr];
      end
    end
  end

  assign bus.ddr_st_addr_out = r_ddr_addr;
  assign bus.ddr_len         = r_ddr_len;
  assign bus.ddr_conf        = r_ddr_conf;
  assign bus.ddr_read_ready  = w_ready;
  assign bus.BP_addr_out     = w_bp_addr;
  assign bus.BP_data_out     = w_bp_data;
  assign bus.BP_wr_en        = r_wr_en;
  assign bus.idle            = (r_state == S_IDLE) && !r_ddr_conf && bus.axi_dg_idle;

endmodule
`default_nettype wire
